// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS channel encoder.
//   CTRL_00..CTRL_11 : 10-bit control-period symbols, indexed by {c1,c0}
//   DISP_W_DEF       : default width of the signed running-disparity counter
//   popcount8        : number of ones in a byte (0..8, 4 bits)
//   s1_t             : stage-1 pipeline payload (transition-minimised word + side info)
package tmds_pkg;

  localparam int DISP_W_DEF = 5;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  typedef struct packed {
    logic [8:0] qm;   // qm[8]=1 -> XOR-coded, 0 -> XNOR-coded
    logic       vde;
    logic [1:0] cd;
  } s1_t;

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(d[i]);
    return n;
  endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// Stage 1 of the TMDS encoder: transition minimisation.
//   clk, rst_n : pixel clock, async active-low reset
//   vd, cd, vde: pixel byte, control pair, video-data enable
//   s1_q       : registered {q_m[8:0], vde, cd}; cleared to control/cd=00 on reset
module tmds_qm_stage
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] vd,
  input  logic [1:0] cd,
  input  logic       vde,
  output s1_t        s1_q
);

  logic [3:0] n1d;
  logic       use_xnor;
  logic [7:0] px;     // prefix parity: px[i] = ^vd[i:0]
  s1_t        s1_d;

  assign n1d      = popcount8(vd);
  assign use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !vd[0]);

  // The serial XOR/XNOR chain is flattened: XOR mode gives plain prefix
  // parity, and each XNOR step adds one inversion, so odd bits flip.
  for (genvar i = 0; i < 8; i++) begin : g_px
    assign px[i] = ^vd[i:0];
  end

  always_comb begin
    s1_d     = '0;
    s1_d.qm  = {~use_xnor, px ^ (use_xnor ? 8'b1010_1010 : 8'b0000_0000)};
    s1_d.vde = vde;
    s1_d.cd  = cd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_q <= '0;
    else        s1_q <= s1_d;
  end

endmodule

// File: rtl/tmds_encoder_pipe.sv
// Two-stage pipelined DVI TMDS 8b/10b encoder, one instance per colour channel.
//   clk   : pixel clock, all logic on posedge
//   rst_n : asynchronous active-low reset
//   vd    : video byte, cd : control {c1,c0}, vde : 1 = video, 0 = control
//   tmds  : 10-bit symbol, bit 0 first on the wire; inputs sampled at one
//           edge are visible on tmds after the following edge
// Stage 1 (tmds_qm_stage) registers the transition-minimised word; stage 2
// applies DC balancing against the running disparity and registers the symbol.
module tmds_encoder_pipe
  import tmds_pkg::*;
#(
  parameter int DISP_W = DISP_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] vd,
  input  logic [1:0] cd,
  input  logic       vde,
  output logic [9:0] tmds
);

  localparam logic signed [DISP_W-1:0] ZERO  = '0;
  localparam logic signed [DISP_W-1:0] TWO   = DISP_W'(2);
  localparam logic signed [DISP_W-1:0] EIGHT = DISP_W'(8);

  s1_t s1_q;

  tmds_qm_stage u_qm (
    .clk   (clk),
    .rst_n (rst_n),
    .vd    (vd),
    .cd    (cd),
    .vde   (vde),
    .s1_q  (s1_q)
  );

  logic [9:0]               tmds_d, tmds_q;
  logic signed [DISP_W-1:0] cnt_d, cnt_q;
  logic signed [DISP_W-1:0] n1_s, n0_s;
  logic [7:0]               qm;
  logic                     qm8;

  assign qm  = s1_q.qm[7:0];
  assign qm8 = s1_q.qm[8];
  // Popcount is zero-extended before going signed so 8 never reads as negative.
  assign n1_s = DISP_W'(popcount8(qm));
  assign n0_s = EIGHT - n1_s;

  always_comb begin
    tmds_d = tmds_q;
    cnt_d  = cnt_q;
    if (!s1_q.vde) begin
      // Any blanking symbol, even a single one, restarts disparity tracking.
      unique case (s1_q.cd)
        2'b00: tmds_d = CTRL_00;
        2'b01: tmds_d = CTRL_01;
        2'b10: tmds_d = CTRL_10;
        2'b11: tmds_d = CTRL_11;
      endcase
      cnt_d = ZERO;
    end else if ((cnt_q == ZERO) || (n1_s == n0_s)) begin
      tmds_d = {~qm8, qm8, qm8 ? qm : ~qm};
      cnt_d  = qm8 ? (cnt_q + (n1_s - n0_s)) : (cnt_q + (n0_s - n1_s));
    end else if (((cnt_q > ZERO) && (n1_s > n0_s)) ||
                 ((cnt_q < ZERO) && (n0_s > n1_s))) begin
      // Word would push disparity further the same way: send it inverted.
      tmds_d = {1'b1, qm8, ~qm};
      cnt_d  = cnt_q + (qm8 ? TWO : ZERO) + (n0_s - n1_s);
    end else begin
      tmds_d = {1'b0, qm8, qm};
      cnt_d  = cnt_q - (qm8 ? ZERO : TWO) + (n1_s - n0_s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmds_q <= CTRL_00;
      cnt_q  <= ZERO;
    end else begin
      tmds_q <= tmds_d;
      cnt_q  <= cnt_d;
    end
  end

  assign tmds = tmds_q;

endmodule

// File: tb/tb_tmds_encoder_pipe.sv
// Scoreboard bench for tmds_encoder_pipe: a behavioural encoder model pushes
// the expected symbol and disparity for every driven pixel; the entry is
// popped and compared when the DUT presents that symbol.
module tb_tmds_encoder_pipe;

  localparam logic [9:0] K00 = 10'b1101010100;
  localparam logic [9:0] K01 = 10'b0010101011;
  localparam logic [9:0] K10 = 10'b0101010100;
  localparam logic [9:0] K11 = 10'b1010101011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] vd = '0;
  logic [1:0] cd = '0;
  logic       vde = 1'b0;
  logic [9:0] tmds;

  tmds_encoder_pipe #(.DISP_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vd    (vd),
    .cd    (cd),
    .vde   (vde),
    .tmds  (tmds)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] sym;
    int         cnt;
    logic       vde;
    logic [7:0] vd;
  } exp_t;

  exp_t sb[$];
  int   m_cnt = 0;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", tag, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_push(input logic [7:0] d, input logic [1:0] c, input logic v);
    exp_t e;
    logic [7:0] q;
    logic       xn;
    int n1d, n1, n0, q8;
    n1d = $countones(d);
    xn  = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q8 = xn ? 0 : 1;
    n1 = $countones(q);
    n0 = 8 - n1;
    if (!v) begin
      case (c)
        2'b00: e.sym = K00;
        2'b01: e.sym = K01;
        2'b10: e.sym = K10;
        default: e.sym = K11;
      endcase
      m_cnt = 0;
    end else if (m_cnt == 0 || n1 == n0) begin
      e.sym = {~q8[0], q8[0], (q8 != 0) ? q : ~q};
      m_cnt = m_cnt + ((q8 != 0) ? (n1 - n0) : (n0 - n1));
    end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
      e.sym = {1'b1, q8[0], ~q};
      m_cnt = m_cnt + 2 * q8 + (n0 - n1);
    end else begin
      e.sym = {1'b0, q8[0], q};
      m_cnt = m_cnt - 2 * (1 - q8) + (n1 - n0);
    end
    e.cnt = m_cnt;
    e.vde = v;
    e.vd  = d;
    sb.push_back(e);
  endtask

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] q, d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  task automatic compare_out();
    exp_t e;
    int   c;
    c = int'($signed(dut.cnt_q));
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("tmds", int'(tmds), int'(e.sym));
      chk("cnt", c, e.cnt);
      if (e.vde) chk("decode", int'(decode(tmds)), int'(e.vd));
    end
    chk("cnt_bound", int'(c <= 10 && c >= -10), 1);
  endtask

  // One pixel: drive on the falling edge, compare just after the rising edge.
  task automatic step(input logic [7:0] d, input logic [1:0] c, input logic v);
    @(negedge clk);
    vd = d; cd = c; vde = v;
    model_push(d, c, v);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  // Async reset mid-line; inputs toggle while held, output must stay CTRL_00.
  task automatic pulse_reset(input int cyc);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_async", int'(tmds), int'(K00));
    chk("rst_cnt", int'($signed(dut.cnt_q)), 0);
    for (int i = 0; i < cyc; i++) begin
      vd = 8'($urandom); cd = 2'($urandom); vde = 1'($urandom);
      @(posedge clk);
      #1;
      chk("rst_hold", int'(tmds), int'(K00));
    end
    rst_n = 1'b1;
    sb.delete();
    m_cnt = 0;
    begin
      exp_t e;
      e.sym = K00; e.cnt = 0; e.vde = 1'b0; e.vd = '0;
      sb.push_back(e);
    end
  endtask

  initial begin
    pulse_reset(4);
    step(8'h00, 2'b00, 1'b0);
    step(8'h00, 2'b00, 1'b0);
    chk("rel_idle", int'(tmds), int'(K00));

    // Control symbols
    step(8'h00, 2'b01, 1'b0);
    step(8'h00, 2'b10, 1'b0);
    chk("ctl01", int'(tmds), int'(K01));
    step(8'h00, 2'b11, 1'b0);
    chk("ctl10", int'(tmds), int'(K10));
    step(8'h00, 2'b00, 1'b0);
    chk("ctl11", int'(tmds), int'(K11));

    // Zero data twice, single-cycle blank, then zero again, then 0xFF runs
    step(8'h00, 2'b00, 1'b1);
    step(8'h00, 2'b00, 1'b1);
    chk("zero1", int'(tmds), int'(10'b0100000000));
    chk("zero1_cnt", int'($signed(dut.cnt_q)), -8);
    step(8'h00, 2'b00, 1'b0);
    chk("zero2", int'(tmds), int'(10'b1111111111));
    chk("zero2_cnt", int'($signed(dut.cnt_q)), 2);
    step(8'h00, 2'b00, 1'b1);
    chk("blank_cnt", int'($signed(dut.cnt_q)), 0);
    step(8'hFF, 2'b00, 1'b1);
    chk("post_blank", int'(tmds), int'(10'b0100000000));
    step(8'h00, 2'b00, 1'b0);
    chk("ff_neg", int'(tmds), int'(10'b0011111111));
    chk("ff_neg_cnt", int'($signed(dut.cnt_q)), -2);
    step(8'hFF, 2'b00, 1'b1);
    step(8'h00, 2'b00, 1'b0);
    chk("full", int'(tmds), int'(10'b1000000000));
    chk("full_cnt", int'($signed(dut.cnt_q)), -8);
    step(8'h00, 2'b00, 1'b0);

    // Random soak with periodic mid-line resets
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] d;
      int r;
      if (i % 700 == 350) pulse_reset(1 + int'($urandom_range(0, 2)));
      r = int'($urandom_range(0, 3));
      d = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
      step(d, 2'($urandom), ($urandom_range(0, 7) != 0));
    end

    // Drain what remains in flight
    step(8'h00, 2'b00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
